// File: rtl/sort_pkg.sv
// Shared definitions for the bitonic sorter stream adapters.
//   state_e   : stream FSM states (IDLE, STREAM)
//   idx_w()   : index width for an N-element vector (at least 1 bit)
//   slice_lo(): LSB position of element k in a flat vector of w-bit elements
package sort_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/sort_stream_out.sv
// Parallel-to-serial output stage for the bitonic sorter.
// Captures data_in on a rising edge of done and streams the elements out
// one per valid/ready beat, element 0 (least-significant slice) first.
//   clk, reset      : clock, asynchronous active-low reset
//   data_in, done   : sorted vector and its result-valid level
//   out_data/out_valid/out_ready/out_index/out_last : stream interface
//   busy            : high while streaming
//   overrun         : sticky, a done rise arrived while a vector was still in flight
module sort_stream_out
  import sort_pkg::*;
#(
  parameter int unsigned NUM_INPUT  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] data_in,
  input  logic                            done,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(NUM_INPUT)-1:0]    out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun
);

  localparam int unsigned IW = idx_w(NUM_INPUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUT - 1);

  state_e                        state;
  logic [NUM_INPUT*DATA_WIDTH-1:0] cap;
  logic [IW-1:0]                 idx;
  logic                          done_q;
  logic                          rise, hs, at_last;

  // done_q resets low so a level already high after reset counts as a rise.
  assign rise    = done & ~done_q;
  assign at_last = (idx == LAST_IDX);
  assign hs      = (state == STREAM) & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cap     <= '0;
      idx     <= '0;
      done_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done_q <= done;
      case (state)
        IDLE: begin
          if (rise) begin
            cap   <= data_in;
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (hs && !at_last) begin
            idx <= idx + 1'b1;
          end else if (hs && at_last) begin
            idx <= '0;
            // A rise coinciding with the final beat reloads with no bubble.
            if (rise) cap   <= data_in;
            else      state <= IDLE;
          end
          if (rise && !(hs && at_last)) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == STREAM);
  assign out_valid = busy;
  assign out_index = idx;
  assign out_last  = busy & at_last;
  assign out_data  = busy ? cap[slice_lo(32'(idx), DATA_WIDTH) +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_sort_stream_out.sv
// Directed bench for sort_stream_out with NUM_INPUT=4, DATA_WIDTH=8.
module tb_sort_stream_out;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*DW-1:0] data_in;
  logic          done;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  sort_stream_out #(.NUM_INPUT(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .done     (done),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects beat 0 of vec visible now, ready held high. With b2b set, a new
  // rise carrying nxt is presented alongside the final beat.
  task automatic stream_check(input logic [31:0] vec, input bit b2b, input logic [31:0] nxt);
    logic [31:0] v;
    v = vec;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("data",  32'(out_data), 32'(v[8*k +: 8]));
      chk("index", 32'(out_index), 32'(k));
      chk("last",  32'(out_last), 32'(k == N-1));
      if (b2b && k == N-1) begin
        data_in = nxt;
        done    = 1'b1;
      end
      step();
    end
    if (!b2b) begin
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_busy",  32'(busy), 32'd0);
    end
  endtask

  task automatic capture(input logic [31:0] vec);
    data_in = vec;
    done    = 1'b1;
    step();
    done    = 1'b0;
  endtask

  initial begin
    int hs;
    int k;
    logic [31:0] v;
    logic [7:0]  bp_exp [4];
    logic        pat [8];

    reset = 1'b0; done = 1'b0; out_ready = 1'b0; data_in = '0;
    #12;
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_last",    32'(out_last), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_index",   32'(out_index), 32'd0);
    chk("rst_data",    32'(out_data), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Basic
    out_ready = 1'b1;
    capture(32'h40302010);
    stream_check(32'h40302010, 1'b0, 32'h0);

    // Backpressure: pattern 1,0,0,1 repeating
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bp_exp = '{8'h10, 8'h20, 8'h30, 8'h40};
    out_ready = 1'b0;
    capture(32'h40302010);
    k = 0;
    for (int c = 0; c < 20 && k < N; c++) begin
      out_ready = pat[c % 8];
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data), 32'(bp_exp[k]));
      chk("bp_index", 32'(out_index), 32'(k));
      if (out_ready) k++;
      step();
    end
    chk("bp_beats", 32'(k), 32'd4);
    chk("bp_idle",  32'(out_valid), 32'd0);

    // Level done held for 20 cycles
    out_ready = 1'b1;
    data_in = 32'h44332211;
    done = 1'b1;
    step();
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) hs++;
      step();
    end
    chk("lvl_beats",   32'(hs), 32'd4);
    chk("lvl_overrun", 32'(overrun), 32'd0);
    chk("lvl_idle",    32'(out_valid), 32'd0);
    done = 1'b0;
    step();

    // Back-to-back reload on the final handshake
    capture(32'h04030201);
    stream_check(32'h04030201, 1'b1, 32'hD0C0B0A0);
    done = 1'b0;
    chk("b2b_valid",   32'(out_valid), 32'd1);
    chk("b2b_data",    32'(out_data), 32'hA0);
    chk("b2b_index",   32'(out_index), 32'd0);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    stream_check(32'hD0C0B0A0, 1'b0, 32'h0);

    // Overrun: rise while element 1 is presented
    capture(32'h40302010);
    chk("ov_pre", 32'(overrun), 32'd0);
    step();
    chk("ov_idx1", 32'(out_index), 32'd1);
    data_in = 32'hFFEEDDCC;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("ov_flag", 32'(overrun), 32'd1);
    chk("ov_d2",   32'(out_data), 32'h30);
    chk("ov_i2",   32'(out_index), 32'd2);
    step();
    chk("ov_d3",   32'(out_data), 32'h40);
    chk("ov_last", 32'(out_last), 32'd1);
    step();
    chk("ov_idle", 32'(busy), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'd1);

    // Reset asserted mid-stream at index 2
    capture(32'h88776655);
    step();
    step();
    out_ready = 1'b0;
    chk("mr_idx2", 32'(out_index), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid",   32'(out_valid), 32'd0);
    chk("mr_busy",    32'(busy), 32'd0);
    chk("mr_index",   32'(out_index), 32'd0);
    chk("mr_data",    32'(out_data), 32'd0);
    chk("mr_overrun", 32'(overrun), 32'd0);
    step();
    reset = 1'b1;
    step();
    out_ready = 1'b1;
    v = 32'h1D1C1B1A;
    capture(v);
    stream_check(v, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
